// File: rtl/fft_result_reader.sv
// Streams the 32 FFT result words out of the result memory once per fft_done rise.
// The reads go through a 2-entry skid FIFO with a valid/ready handshake. Define BIT_REVERSE_READ_EN to read addresses in bit-reversed order.
module fft_result_reader #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              fft_done,
  output logic [4:0]        rd_address,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [4:0]        dout_index,
  output logic              dout_last,
  output logic              busy,
  output logic              read_done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t            state;
  logic              fft_done_q;
  logic [4:0]        issue_cnt;
  logic              inflight_q;
  logic [4:0]        inflight_idx;
  logic [1:0]        fifo_cnt;
  logic [DATA_W-1:0] head_data, tail_data;
  logic [4:0]        head_idx, tail_idx;
  logic              read_done_q;

  logic              start;
  logic              head_valid;
  logic              xfer;
  logic              issue;
  logic [2:0]        level;
  logic [4:0]        mapped_addr;

  assign start      = fft_done & ~fft_done_q;
  assign head_valid = (fifo_cnt != 2'd0);
  assign xfer       = head_valid & dout_ready;

  // Words already held plus the one in flight, minus the one leaving now.
  // A new read is issued only if its data is sure to find a free FIFO slot.
  assign level = {1'b0, fifo_cnt} + {2'b00, inflight_q} - {2'b00, xfer};
  assign issue = ~clr & (state == READ) & (level < 3'd2);

`ifdef BIT_REVERSE_READ_EN
  assign mapped_addr = {issue_cnt[0], issue_cnt[1], issue_cnt[2], issue_cnt[3], issue_cnt[4]};
`else
  assign mapped_addr = issue_cnt;
`endif

  // clr forces every output to its idle value in the same cycle, not only after the edge.
  assign rd_en      = issue;
  assign rd_address = clr ? 5'd0 : mapped_addr;
  assign dout_valid = ~clr & head_valid;
  assign dout       = clr ? '0 : head_data;
  assign dout_index = clr ? 5'd0 : head_idx;
  assign dout_last  = ~clr & head_valid & (head_idx == 5'd31);
  assign busy       = ~clr & (state != IDLE);
  assign read_done  = ~clr & read_done_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      state        <= IDLE;
      fft_done_q   <= 1'b1;
      issue_cnt    <= 5'd0;
      inflight_q   <= 1'b0;
      inflight_idx <= 5'd0;
      fifo_cnt     <= 2'd0;
      head_data    <= '0;
      head_idx     <= 5'd0;
      read_done_q  <= 1'b0;
      // NOTE: the tail entry is not reset. It is only read after it has been written.
    end else begin
      // NOTE: use non-blocking assignments throughout so every register here sees pre-edge values.
      fft_done_q  <= fft_done;
      read_done_q <= 1'b0;
      inflight_q  <= issue;
      if (issue) begin
        inflight_idx <= issue_cnt;
        issue_cnt    <= issue_cnt + 5'd1;
      end

      case (state)
        IDLE: if (start) begin
          state     <= READ;
          issue_cnt <= 5'd0;
        end
        READ: if (issue && issue_cnt == 5'd31) state <= DRAIN;
        DRAIN: if (xfer && head_idx == 5'd31) begin
          state       <= IDLE;
          read_done_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase

      // A push always comes from the read issued in the previous cycle.
      case ({inflight_q, xfer})
        2'b10: begin
          if (fifo_cnt == 2'd0) begin
            head_data <= rd_data;
            head_idx  <= inflight_idx;
          end else begin
            tail_data <= rd_data;
            tail_idx  <= inflight_idx;
          end
          fifo_cnt <= fifo_cnt + 2'd1;
        end
        2'b01: begin
          head_data <= tail_data;
          head_idx  <= tail_idx;
          fifo_cnt  <= fifo_cnt - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt == 2'd1) begin
            head_data <= rd_data;
            head_idx  <= inflight_idx;
          end else begin
            head_data <= tail_data;
            head_idx  <= tail_idx;
            tail_data <= rd_data;
            tail_idx  <= inflight_idx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_result_reader.sv
// Self-checking bench for fft_result_reader.
// A behavioural memory and a per-run expected queue check delivery order, the handshake and the latency.
module tb_fft_result_reader;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              clr;
  logic              fft_done;
  logic [4:0]        rd_address;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data = '0;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic [4:0]        dout_index;
  logic              dout_last;
  logic              busy;
  logic              read_done;

  logic [DATA_W-1:0] mem [32];
  int checks = 0;
  int errors = 0;

  fft_result_reader #(.DATA_W(DATA_W)) dut (
    .clk(clk), .clr(clr), .fft_done(fft_done),
    .rd_address(rd_address), .rd_en(rd_en), .rd_data(rd_data),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_index(dout_index), .dout_last(dout_last),
    .busy(busy), .read_done(read_done)
  );

  always #5 clk = ~clk;

  // Result memory: data appears one cycle after the read strobe.
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_address];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] addr_of(input int bin);
    int r;
    r = 0;
`ifdef BIT_REVERSE_READ_EN
    for (int i = 0; i < 5; i++) if (((bin >> i) & 1) != 0) r = r | (1 << (4 - i));
`else
    r = bin;
`endif
    return r[4:0];
  endfunction

  function automatic logic ready_for(input int mode, input int cyc);
    case (mode)
      0: return 1'b1;
      1: return (cyc % 4 == 0) || (cyc % 4 == 3);
      default: return ($urandom_range(0, 99) < 60);
    endcase
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_address"}, rd_address, 0);
    check({tag, "_dout_valid"}, dout_valid, 0);
    check({tag, "_dout_last"}, dout_last, 0);
    check({tag, "_dout_index"}, dout_index, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_read_done"}, read_done, 0);
    check({tag, "_dout"}, dout, 0);
  endtask

  // mode: 0 ready always high, 1 ready pattern 1,0,0,1, 2 random ready.
  // glitch: drop and raise fft_done mid-run. abort_bin: pulse clr when this bin is at the head.
  task automatic run_one(input int mode, input bit glitch, input int abort_bin);
    logic [DATA_W-1:0] exp_q [$];
    int cyc, issued, xfers, held, first_valid, done_cyc, last_cyc;
    logic prev_rd, prev_stall, xfer_now;
    logic [DATA_W-1:0] prev_dout;
    logic [4:0] prev_idx;
    logic prev_last;
    logic [DATA_W-1:0] exp_word;

    for (int b = 0; b < 32; b++) exp_q.push_back(mem[addr_of(b)]);
    cyc = 0; issued = 0; xfers = 0; first_valid = -1; done_cyc = -1; last_cyc = -1;
    prev_rd = 1'b0; prev_stall = 1'b0; prev_dout = '0; prev_idx = '0; prev_last = 1'b0;

    @(negedge clk); fft_done = 1'b0; dout_ready = 1'b1;
    @(negedge clk); fft_done = 1'b1;   // start is detected in this cycle (cycle T)

    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      dout_ready = ready_for(mode, cyc);
      if (glitch && cyc == 10) fft_done = 1'b0;
      if (glitch && cyc == 11) fft_done = 1'b1;
      #1;
      if (mode == 0 && cyc == 1) begin
        check("first_rd_en", rd_en, 1);
        check("first_rd_address", rd_address, addr_of(0));
      end

      if (abort_bin >= 0 && dout_valid && dout_index == abort_bin[4:0]) begin
        clr = 1'b1;
        #1;
        check_idle_outputs("clr_mid_run");
        @(negedge clk); clr = 1'b0; #1;
        check("after_clr_valid", dout_valid, 0);
        check("after_clr_busy", busy, 0);
        for (int i = 0; i < 6; i++) begin
          @(negedge clk); #1;
          if (busy || rd_en) break;
        end
        check("no_restart_busy", busy, 0);
        check("no_restart_rd_en", rd_en, 0);
        return;
      end

      // Words whose read was issued two or more cycles ago are held; last cycle's read is in flight.
      xfer_now = dout_valid & dout_ready;
      held = issued - int'(prev_rd) - xfers;
      if (rd_en) begin
        check("rd_en_room", (held + int'(prev_rd) - int'(xfer_now)) < 2, 1);
        check("rd_en_count", issued < 32, 1);
        check("rd_address", rd_address, addr_of(issued));
      end

      if (dout_valid && first_valid < 0) first_valid = cyc;
      if (dout_valid && prev_stall) begin
        check("stall_dout", dout, prev_dout);
        check("stall_index", dout_index, prev_idx);
        check("stall_last", dout_last, prev_last);
      end
      if (xfer_now) begin
        exp_word = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check("xfer_extra", xfers < 32, 1);
        check("dout", dout, exp_word);
        check("dout_index", dout_index, xfers);
        check("dout_last", dout_last, xfers == 31);
        xfers++;
        if (xfers == 32) last_cyc = cyc;
      end
      if (read_done) begin
        done_cyc = cyc;
        break;
      end

      if (rd_en) issued++;
      prev_rd = rd_en;
      prev_stall = dout_valid & ~dout_ready;
      prev_dout = dout; prev_idx = dout_index; prev_last = dout_last;
    end

    check("read_done_seen", done_cyc >= 0, 1);
    check("total_xfers", xfers, 32);
    check("total_reads", issued, 32);
    if (mode == 0) begin
      check("first_valid_cycle", first_valid, 3);
      check("last_xfer_cycle", last_cyc, 34);
      check("read_done_cycle", done_cyc, 35);
    end
    @(negedge clk); #1;
    check("post_busy", busy, 0);
    check("post_read_done", read_done, 0);
    check("post_valid", dout_valid, 0);
    repeat (4) @(negedge clk);
    #1;
    check("post_no_restart", busy, 0);
  endtask

  initial begin
    int ever_busy;
    clr = 1'b1; fft_done = 1'b0; dout_ready = 1'b0;
    for (int k = 0; k < 32; k++) mem[k] = DATA_W'(k * 3);
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    clr = 1'b0;

    run_one(0, 1'b0, -1);
    run_one(1, 1'b0, -1);
    for (int k = 0; k < 32; k++) mem[k] = $urandom;
    run_one(2, 1'b0, -1);
    run_one(0, 1'b1, -1);
    run_one(0, 1'b0, 10);
    run_one(2, 1'b0, -1);

    // fft_done already high when clr releases must not start a run.
    @(negedge clk); clr = 1'b1; fft_done = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    ever_busy = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      if (busy || rd_en) ever_busy = 1;
    end
    check("clr_release_high_no_run", ever_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fft_result_reader.md
FFT_RESULT_READER -- requirements
Module: fft_result_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 32, memory word width (real/imag packed).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port clr  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port fft_done  input  1  level from the FFT address generator, high when the transform is complete.
REQ-005 SHALL have port rd_address  output  5  result-memory read address.
REQ-006 SHALL have port rd_en  output  1  read strobe; rd_data is valid exactly 1 cycle after rd_en.
REQ-007 SHALL have port rd_data  input  DATA_W  result-memory read data.
REQ-008 SHALL have port dout  output  DATA_W  output sample.
REQ-009 SHALL have port dout_valid  output  1  dout holds a valid sample.
REQ-010 SHALL have port dout_ready  input  1  downstream accepts; transfer occurs when dout_valid & dout_ready.
REQ-011 SHALL have port dout_index  output  5  frequency-bin index of dout, 0..31.
REQ-012 SHALL have port dout_last  output  1  high with dout_valid for bin 31.
REQ-013 SHALL have port busy  output  1  high in states READ and DRAIN.
REQ-014 SHALL have port read_done  output  1  one-cycle pulse after the final transfer.

Function
REQ-015 SHALL implement states IDLE, READ, DRAIN.
REQ-016 SHALL register fft_done each cycle and detect start as fft_done high while the registered copy is low.
REQ-017 IDLE -> READ SHALL occur on the cycle after start is detected; start in READ or DRAIN SHALL be ignored.
REQ-018 In READ, rd_en SHALL assert only when (buffered words + in-flight read - transfer this cycle) < 2.
REQ-019 An issue counter (5 bits, starting at 0) SHALL increment on each rd_en.
REQ-020 READ -> DRAIN SHALL occur on the cycle the read for issue count 31 is issued; no rd_en in DRAIN or IDLE.
REQ-021 Returned rd_data SHALL enter a 2-entry FIFO whose head drives dout, dout_index, dout_last; no word SHALL be dropped or duplicated under any dout_ready pattern.
REQ-022 dout, dout_index and dout_last SHALL hold stable while dout_valid & ~dout_ready.
REQ-023 Latency SHALL be as follows: start detected in cycle T, rd_en with address of bin 0 in T+1, dout_valid in T+3.
REQ-024 With dout_ready held high, one word SHALL transfer per cycle, bins 0..31 in cycles T+3..T+34.
REQ-025 DRAIN -> IDLE SHALL occur on the transfer with dout_last; read_done SHALL pulse high in the following cycle.
REQ-026 After a run, a new start SHALL require fft_done to go low for at least one cycle and then high again.
REQ-027 dout_index SHALL equal the bin count 0..31 and SHALL wrap to 0 only at the start of a new run.

Reset
REQ-028 clr SHALL take priority over all other inputs, including during READ or DRAIN.
REQ-029 While clr is high, the block SHALL enter IDLE, empty the FIFO, discard any in-flight read, and clear both counters.
REQ-030 While clr is high, outputs SHALL be rd_en=0, rd_address=0, dout_valid=0, dout_last=0, dout_index=0, busy=0, read_done=0, dout=0.
REQ-031 While clr is high, the registered fft_done SHALL be set to 1, so a level already high at reset release does not start a run.

Configuration
REQ-032 Macro BIT_REVERSE_READ_EN SHALL select the address mapping.
REQ-033 With BIT_REVERSE_READ_EN defined, rd_address SHALL be the 5-bit bit-reversal of the issue count, e.g. count 1 -> address 16 and count 6 -> address 12.
REQ-034 Without BIT_REVERSE_READ_EN, rd_address SHALL equal the issue count.
REQ-035 In both builds, dout_index SHALL be the natural bin order 0..31.

Verification
REQ-036 Memory word k = k*3; clr deasserted; fft_done rises in cycle T; dout_ready=1 -> dout_valid first in T+3, values bin-ordered, dout_last at bin 31, read_done in T+35, busy low afterwards.
REQ-037 dout_ready toggles 1,0,0,1 repeating -> all 32 words delivered exactly once and in order, dout stable while stalled, rd_en never issued with 2 words held plus 1 in flight.
REQ-038 BIT_REVERSE_READ_EN defined -> rd_address sequence begins 0,16,8,24,4; dout_index 0..31.
REQ-039 clr pulsed for 1 cycle at bin 10 -> next cycle dout_valid=0, busy=0; with fft_done still high no restart; after fft_done goes low then high, a full run starts from bin 0.
REQ-040 fft_done pulsed again mid-run -> ignored, exactly 32 transfers; fft_done high at clr release -> no run.
